// File: rtl/binary_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (double-dabble) with overflow and leading-zero blanking.
// Latency: 15 cycles from the accepted start edge to done; start is ignored while busy (no queuing).
module binary_to_bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin_in,
  input  logic        blank_lz,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  BCD_3,
  output logic [3:0]  BCD_2,
  output logic [3:0]  BCD_1,
  output logic [3:0]  BCD_0
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t      state, state_nxt;
  logic [15:0] acc;
  logic [15:0] acc_adj;
  logic [13:0] bin_q;
  logic [3:0]  cnt;
  logic        blank_q;
  logic        ovf_q;
  logic        blank3, blank2, blank1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd13) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Add-3 correction applied to every nibble before each shift
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Blanking cascades from the thousands digit downward; units is never blanked
  assign blank3 = blank_q && (acc[15:12] == 4'd0);
  assign blank2 = blank3  && (acc[11:8]  == 4'd0);
  assign blank1 = blank2  && (acc[7:4]   == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= 16'd0;
      bin_q    <= 14'd0;
      cnt      <= 4'd0;
      blank_q  <= 1'b0;
      ovf_q    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      BCD_3    <= 4'd0;
      BCD_2    <= 4'd0;
      BCD_1    <= 4'd0;
      BCD_0    <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_q   <= bin_in;
            blank_q <= blank_lz;
            ovf_q   <= (bin_in > 14'd9999);
            acc     <= 16'd0;
            cnt     <= 4'd0;
          end
        end
        SHIFT: begin
          acc   <= (acc_adj << 1) | {15'd0, bin_q[13]};
          bin_q <= bin_q << 1;
          cnt   <= cnt + 4'd1;
        end
        FINISH: begin
          done <= 1'b1;
          if (ovf_q) begin
            overflow <= 1'b1;
            BCD_3    <= 4'hF;
            BCD_2    <= 4'hF;
            BCD_1    <= 4'hF;
            BCD_0    <= 4'hF;
          end else begin
            overflow <= 1'b0;
            BCD_3    <= blank3 ? 4'hF : acc[15:12];
            BCD_2    <= blank2 ? 4'hF : acc[11:8];
            BCD_1    <= blank1 ? 4'hF : acc[7:4];
            BCD_0    <= acc[3:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq: a decimal reference model predicts each result at start time.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin_in;
  logic        blank_lz;
  logic        busy, done, overflow;
  logic [3:0]  BCD_3, BCD_2, BCD_1, BCD_0;

  typedef struct {
    logic [16:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [16:0] last_res = 17'd0;

  binary_to_bcd_seq dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in), .blank_lz(blank_lz),
    .busy(busy), .done(done), .overflow(overflow),
    .BCD_3(BCD_3), .BCD_2(BCD_2), .BCD_1(BCD_1), .BCD_0(BCD_0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Decimal reference: {overflow, d3, d2, d1, d0}
  function automatic logic [16:0] ref_bcd(input int v, input bit bl);
    logic [3:0] d3, d2, d1, d0;
    if (v > 9999) return {1'b1, 16'hFFFF};
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    if (bl && d3 == 4'd0) begin
      d3 = 4'hF;
      if (d2 == 4'd0) begin
        d2 = 4'hF;
        if (d1 == 4'd0) d1 = 4'hF;
      end
    end
    return {1'b0, d3, d2, d1, d0};
  endfunction

  // Output monitor: compares on done, checks outputs hold otherwise
  always @(negedge clk) begin
    if (reset) begin
      last_res = 17'd0;
    end else if (done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", {15'd0, overflow, BCD_3, BCD_2, BCD_1, BCD_0}, {15'd0, e.res});
        chk("latency", cyc, e.cyc);
        last_res = e.res;
      end
    end else begin
      chk("hold", {15'd0, overflow, BCD_3, BCD_2, BCD_1, BCD_0}, {15'd0, last_res});
    end
  end

  // Called just after a falling edge; returns at the falling edge after the capture edge
  task automatic drive_start(input int v, input bit bl, input bit expect_it);
    exp_t e;
    start    = 1'b1;
    bin_in   = 14'(v);
    blank_lz = bl;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    bin_in   = 14'($urandom);
    blank_lz = 1'($urandom);
    if (expect_it) begin
      e.res = ref_bcd(v, bl);
      e.cyc = cyc + 15;
      sb_q.push_back(e);
    end
  endtask

  // Returns at the falling edge where done is high; optional ignored-start noise while busy
  task automatic wait_done(input bit noise);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        bin_in = 14'($urandom);
      end
    end
    start = 1'b0;
    if (!seen) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    bin_in   = 14'd0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf",  {31'd0, overflow}, 32'd0);
    chk("rst_bcd",  {16'd0, BCD_3, BCD_2, BCD_1, BCD_0}, 32'd0);
    reset = 1'b0;

    // 1234 with busy window check
    drive_start(1234, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      chk("busy_high", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    chk("busy_low", {31'd0, busy}, 32'd0);
    chk("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // Blanking and range boundaries
    drive_start(7, 1'b1, 1'b1);      wait_done(1'b0);
    drive_start(7, 1'b0, 1'b1);      wait_done(1'b0);
    drive_start(0, 1'b1, 1'b1);      wait_done(1'b0);
    drive_start(9999, 1'b1, 1'b1);   wait_done(1'b0);
    drive_start(10000, 1'b0, 1'b1);  wait_done(1'b0);
    drive_start(105, 1'b1, 1'b1);    wait_done(1'b0);
    drive_start(16383, 1'b1, 1'b1);  wait_done(1'b0);

    // Ignored start mid-conversion, then back-to-back start in the done cycle
    drive_start(1234, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = 14'd5678;
    @(negedge clk);
    start  = 1'b0;
    wait_done(1'b0);
    drive_start(5678, 1'b0, 1'b1);
    wait_done(1'b0);

    // Leave overflow/F digits visible, then abort a conversion with reset
    drive_start(16383, 1'b0, 1'b1);
    wait_done(1'b0);
    drive_start(4321, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_ovf",  {31'd0, overflow}, 32'd0);
    chk("abort_bcd",  {16'd0, BCD_3, BCD_2, BCD_1, BCD_0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    drive_start(42, 1'b0, 1'b1);
    wait_done(1'b0);

    // Random back-to-back conversions with ignored starts while busy
    for (int n = 0; n < 1000; n++) begin
      drive_start(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)), 1'b1);
      wait_done(1'b1);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single system clock; all state changes occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to convert bin_in; sampled only while idle.
REQ-005 bin_in  input  14  unsigned binary value to convert, range 0..16383.
REQ-006 blank_lz  input  1  leading-zero blanking enable; captured together with bin_in.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when new results are valid.
REQ-009 overflow  output  1  high when the last captured bin_in exceeded 9999.
REQ-010 BCD_3, BCD_2, BCD_1, BCD_0  output  4 each  thousands, hundreds, tens and units digits; each digit directly drives one downstream BCD-to-7-segment decoder, where 4'hF displays blank.

Function
REQ-011 The module SHALL use a three-state FSM: IDLE, SHIFT, FINISH.
REQ-012 In IDLE with start=1 at edge k, the module SHALL capture bin_in and blank_lz, clear the 16-bit BCD accumulator and the 4-bit iteration counter, and enter SHIFT.
REQ-013 Each SHIFT edge SHALL first add 3 to every accumulator nibble that is >=5, then shift {accumulator, binary register} left by one bit, then increment the counter (double-dabble).
REQ-014 After the 14th shift, at edge k+14, the FSM SHALL enter FINISH.
REQ-015 At edge k+15 (FINISH), the module SHALL register BCD_3..BCD_0, overflow and done=1, then return to IDLE.
REQ-016 done SHALL be high for exactly one cycle, following edge k+15; fixed latency is start-edge to done equal to 15 cycles, independent of the input value.
REQ-017 busy SHALL be high exactly while the state is SHIFT or FINISH, i.e. after edges k through k+14.
REQ-018 BCD_3..BCD_0 and overflow SHALL hold their values between completions; they change only at the FINISH edge.
REQ-019 start while busy=1 SHALL be ignored, with no queuing.
REQ-020 bin_in and blank_lz changes after capture SHALL NOT affect the conversion in progress.
REQ-021 start=1 in the cycle done=1 is visible SHALL be accepted, since the state is IDLE; back-to-back conversions therefore run with a period of 16 cycles.
REQ-022 If the captured value is greater than 9999, the module SHALL set overflow=1 and drive all four digits to 4'hF at FINISH.
REQ-023 Blanking at FINISH SHALL apply when the captured value is <=9999 and blank_lz=1:
- BCD_3 is 4'hF if it is 0.
- BCD_2 is 4'hF if BCD_3 and BCD_2 are both 0.
- BCD_1 is 4'hF if BCD_3, BCD_2 and BCD_1 are all 0.
- BCD_0 is never blanked.
REQ-024 If the captured value is <=9999, overflow SHALL be 0 at FINISH.
REQ-025 Only digit values 0..9 or 4'hF SHALL ever appear on the BCD outputs.

Reset
REQ-026 Asserting reset SHALL immediately force the following, regardless of clock:
- state IDLE
- busy=0, done=0, overflow=0
- BCD_3..BCD_0 = 0
- internal accumulator and counter cleared
REQ-027 Reset asserted mid-conversion SHALL abort the conversion; no done pulse SHALL follow.
REQ-028 After reset deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Verification
REQ-029 bin_in=1234, blank_lz=0, start pulse at edge k -> busy high for 15 cycles; done at k+15; digits 1,2,3,4; overflow=0.
REQ-030 bin_in=7, blank_lz=1 -> digits F,F,F,7; with blank_lz=0 -> digits 0,0,0,7; bin_in=0, blank_lz=1 -> digits F,F,F,0.
REQ-031 bin_in=9999 -> digits 9,9,9,9, overflow=0; bin_in=10000 and bin_in=16383 -> digits F,F,F,F, overflow=1.
REQ-032 Start 1234, then change bin_in to 5678 and pulse start at k+5 -> result is 1,2,3,4 with a single done; start asserted again in the done cycle with bin_in=5678 -> second done 16 cycles later with digits 5,6,7,8.
REQ-033 Start 4321, assert reset at k+7 -> busy, done and digits read 0 asynchronously; no done pulse; new start 0042 after release -> digits 0,0,4,2 after 15 cycles.
REQ-034 Random bin_in values 0..16383 over at least 1000 conversions -> digits match a reference decimal model, and overflow and blanking follow REQ-022/REQ-023.
